regfile_mp: RTL

Parametrised multi-port integer register file with a built-in scoreboard and a per-register write-enable vector for clock gating. It sits in the decode/writeback path of the pipelined core, replacing the single-write, two-read file. It adds configurable read/write port counts, write-to-read bypass, an optional registered-read mode and busy-bit tracking for hazard detection.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 51 +++++
 rtl/regfile_mp.sv | 107 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] reg_data_t;

  // Address of the hard-wired zero register.
  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set on issue, cleared on writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NRD-1:0][AW-1:0] rd_addr,
  input  logic [NREGS-1:0]       clr_vec,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_rd,
  output logic [NRD-1:0]         rd_busy,
  output logic [NREGS-1:0]       busy_vec
);

  localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

  logic [NREGS-1:0] set_vec;

  always_comb begin
    set_vec = '0;
    if (iss_valid && (iss_rd != ADDR_ZERO)) begin
      set_vec[iss_rd] = 1'b1;
    end
  end

  // Set is applied after clear so an issue and a writeback to the same
  // register in one cycle leave it busy. Bit 0 can never be set or cleared.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_vec <= '0;
    end else begin
      busy_vec <= (busy_vec & ~clr_vec) | set_vec;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_busy[k] = busy_vec[rd_addr[k]];
      if ((BYPASS != 0) && clr_vec[rd_addr[k]]) begin
        rd_busy[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write arbitration, write-to-read bypass,
// optional registered reads and a busy-bit scoreboard for hazard detection.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][AW-1:0]   wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic [NREGS-1:0]         reg_wen,
  output logic [NREGS-1:0]         busy_vec
);

  localparam logic [AW-1:0] ADDR_ZERO = AW'(REG_ZERO);

  // No handshake anywhere: every input is sampled every cycle and nothing
  // can be back-pressured.

  logic [NREGS-1:0]           wen_c;
  logic [NREGS-1:0][XLEN-1:0] win_data;
  logic [XLEN-1:0]            mem [NREGS];
  logic [NRD-1:0][XLEN-1:0]   rd_data_c;
  logic [NRD-1:0]             rd_busy_c;

  // Ports are scanned low to high so the highest-indexed port wins.
  always_comb begin
    wen_c    = '0;
    win_data = '0;
    for (int p = 0; p < NWR; p++) begin
      if (wr_en[p] && (wr_addr[p] != ADDR_ZERO)) begin
        wen_c[wr_addr[p]]    = 1'b1;
        win_data[wr_addr[p]] = wr_data[p];
      end
    end
  end

  assign reg_wen = wen_c;

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!reset_n) begin
        mem[r] <= '0;
      end else if (wen_c[r]) begin
        mem[r] <= win_data[r];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_addr[k] != ADDR_ZERO) begin
        if ((BYPASS != 0) && wen_c[rd_addr[k]]) begin
          rd_data_c[k] = win_data[rd_addr[k]];
        end else begin
          rd_data_c[k] = mem[rd_addr[k]];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRD    (NRD),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_addr   (rd_addr),
    .clr_vec   (wen_c),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .rd_busy   (rd_busy_c),
    .busy_vec  (busy_vec)
  );

  // The registered path captures the already bypass-resolved value.
  if (READ_LAT == 1) begin : g_rd_reg
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        rd_data <= '0;
        rd_busy <= '0;
      end else begin
        rd_data <= rd_data_c;
        rd_busy <= rd_busy_c;
      end
    end
  end else begin : g_rd_comb
    assign rd_data = rd_data_c;
    assign rd_busy = rd_busy_c;
  end

endmodule
